axi_w_router: RTL and testbench
===============================

# axi_w_router

Write-data router of the 2-master / 4-slave AXI interconnect, directly downstream of the AW arbiter. It records, in issue order, which master won each accepted AW transfer and which slave that address decodes to. It then steers that master's W beats to that slave, one complete burst (through WLAST) at a time. AXI write ordering is preserved by construction, and masters and slaves outside the active route are held off.

## Interface
Parameters:
- `DATA_W`, default `DATA_WIDTH`: W data width; strobe width is `DATA_W/8`.
- `DEPTH`, default 16: number of outstanding write-order entries; must be a power of 2, at least 2.
- `NUM_SLV`, default 4: number of slave ports; the slave select is `$clog2(NUM_SLV)` bits.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk_i`, in, 1: clock; everything is on the rising edge.
  - `rst_i`, in, 1: asynchronous, active-high reset.
- AW-side order capture:
  - `aw_push_i`, in, 1: AW handshake completed this cycle (AWVALID && AWREADY at the arbiter output).
  - `aw_msel_i`, in, 1: winning master (0 = m0 cpu, 1 = m1 dmac).
  - `aw_ssel_i`, in, 2: target slave, equal to AWADDR[ADDR_WIDTH-1 -: 2].
  - `aw_full_o`, out, 1: order FIFO full; the arbiter must gate AWREADY with ~aw_full_o.
- Master-side W signals (`mX` = `m0`, `m1`):
  - `mX_WDATA`, in, DATA_W.
  - `mX_WSTRB`, in, DATA_W/8.
  - `mX_WVALID`, in, 1.
  - `mX_WLAST`, in, 1.
  - `mX_WREADY`, out, 1.
- Slave-side W signals, packed arrays indexed by slave:
  - `s_WDATA`, out, [NUM_SLV][DATA_W].
  - `s_WSTRB`, out, [NUM_SLV][DATA_W/8].
  - `s_WVALID`, out, [NUM_SLV].
  - `s_WLAST`, out, [NUM_SLV].
  - `s_WREADY`, in, [NUM_SLV].
- Status:
  - `busy_o`, out, 1: a route is active.
  - `beat_cnt_o`, out, 8: beats of the current burst accepted so far.
  - `ovf_o`, out, 1: sticky flag; a push was attempted while the FIFO was full.

## Operation
- **Order FIFO:** each entry is {ssel, msel}.
  - A push writes on `aw_push_i && !aw_full_o`.
  - A pop occurs on the last-beat handshake (see Burst transfer).
  - Push and pop in the same cycle are both performed, including when full (pop frees a slot first) and when count = 1.
  - `aw_push_i` while full is dropped and sets `ovf_o`, which only reset clears.
- **State machine:**
  - IDLE → ACTIVE when the FIFO is non-empty.
  - ACTIVE → IDLE when the last beat is accepted and the FIFO will then be empty.
  - ACTIVE → ACTIVE when the last beat is accepted and more entries remain; the next burst follows with no bubble.
- **Routing in ACTIVE:** the head entry selects master M = head.msel and slave S = head.ssel.
  - s_W{DATA,STRB,LAST}[S] = mM_W{DATA,STRB,LAST}.
  - s_WVALID[S] = mM_WVALID.
  - mM_WREADY = s_WREADY[S].
  - All other s_WVALID are 0 and the other master's WREADY is 0.
  - Data and strobe of unselected slaves are driven to 0.
- **Burst transfer:**
  - A beat is accepted when s_WVALID[S] && s_WREADY[S].
  - Each accepted beat increments `beat_cnt_o`, saturating at 255.
  - The last beat is an accepted beat with WLAST = 1; it pops the FIFO and clears `beat_cnt_o` to 0.
- **IDLE:** all WREADY = 0 and all s_WVALID = 0. W beats presented before their AW entry exists stall.
- **Defined but unsupported case:** an empty-slave-index entry (e.g. ssel = 2 on a read-only map) routes normally; address decode errors are not handled here.

## Timing
- Reset values: all outputs 0, FIFO empty, state IDLE, `ovf_o` = 0, `beat_cnt_o` = 0.
- Reset mid-burst aborts the route immediately and drops every outstanding entry.
- The W path is purely combinational between master and slave: 0-cycle latency for valid, data and ready.
- AW-to-W latency: a push at edge N makes the route visible after edge N (cycle N+1). There is no same-cycle bypass from `aw_push_i`.
- Back-to-back bursts: the last beat at cycle N means the next head's route is live in cycle N+1.
- `aw_full_o` is registered-derived (from the count), with no combinational path from `aw_push_i`.
- `busy_o` = state == ACTIVE.

## Structure
- Select widths, master encoding (MSEL_CPU = 0, MSEL_DMAC = 1) and the slave-index constants go in the shared interconnect package, alongside `ID_BITS`, `DATA_WIDTH` and `ADDR_WIDTH`.
- One sub-module: the existing `fifo` (DATA_W = 3, DEPTH = DEPTH) serves as the order FIFO, extended with a count output for same-cycle push/pop-when-full.
- The FSM, router mux and beat counter sit in the top body.

## Test plan
- **Single burst:** push {ssel = 1, msel = 0}, then m0 sends 4 beats 0xA0..0xA3 with WLAST on the 4th and s1 WREADY = 1 → s1 sees 4 beats in order, `beat_cnt_o` goes 1, 2, 3, then 0, FIFO empties, IDLE next cycle, and m1_WREADY stays 0 throughout.
- **Interleaved order:** push {3, 1} then {0, 0} while both masters hold WVALID → m1's burst goes to s3 first and completes, then m0's burst goes to s0 in the next cycle with no bubble. m0_WREADY is 0 until m1's WLAST is accepted.
- **Backpressure:** s2 WREADY toggles 1/0 each cycle during an 8-beat m1 burst → exactly 8 accepts, data unchanged while stalled, and pop only on the 8th accept.
- **Full FIFO:** DEPTH pushes with no W activity → `aw_full_o` = 1. A further push sets `ovf_o` and leaves the FIFO unchanged. Accepting a last beat in the same cycle as a push keeps count = DEPTH, with the new entry stored.
- **Early W:** m0 drives WVALID with no entry → m0_WREADY = 0 and no s_WVALID. Push {0, 0} at edge N → m0_WREADY = s_WREADY[0] from cycle N+1.
- **Reset mid-burst:** assert `rst_i` after 2 of 4 beats → all outputs 0 asynchronously, FIFO empty after release, and a fresh push routes correctly.

Source files
------------

// File: rtl/axi_w_router_pkg.sv
// Shared interconnect constants and the write-order entry type.
// No ports: provides data/address/ID widths, master and slave select encodings,
// and the {ssel, msel} entry stored by the W router order FIFO.
package axi_w_router_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned ID_BITS    = 4;

  localparam int unsigned MSEL_W = 1;
  localparam int unsigned SSEL_W = 2;

  localparam logic [MSEL_W-1:0] MSEL_CPU  = 1'b0;
  localparam logic [MSEL_W-1:0] MSEL_DMAC = 1'b1;

  localparam logic [SSEL_W-1:0] SLV_0 = 2'd0;
  localparam logic [SSEL_W-1:0] SLV_1 = 2'd1;
  localparam logic [SSEL_W-1:0] SLV_2 = 2'd2;
  localparam logic [SSEL_W-1:0] SLV_3 = 2'd3;

  // One outstanding write: target slave and winning master, in AW issue order.
  typedef struct packed {
    logic [SSEL_W-1:0] ssel;
    logic [MSEL_W-1:0] msel;
  } w_order_t;

  localparam int unsigned ORDER_W = $bits(w_order_t);

endpackage

// File: rtl/axi_w_router_if.sv
// W channel bundle between the two masters, the router and the slave ports.
// Signals: m0_W*/m1_W* (master side), s_W* packed arrays indexed by slave.
// Modports: master = the environment (masters drive W, slaves drive WREADY);
//           slave  = the router, which consumes master W and drives slave W.
interface axi_w_router_if
  import axi_w_router_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_WIDTH,
  parameter int unsigned NUM_SLV = 4
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] m0_WDATA;
  logic [STRB_W-1:0] m0_WSTRB;
  logic              m0_WVALID;
  logic              m0_WLAST;
  logic              m0_WREADY;

  logic [DATA_W-1:0] m1_WDATA;
  logic [STRB_W-1:0] m1_WSTRB;
  logic              m1_WVALID;
  logic              m1_WLAST;
  logic              m1_WREADY;

  logic [NUM_SLV-1:0][DATA_W-1:0] s_WDATA;
  logic [NUM_SLV-1:0][STRB_W-1:0] s_WSTRB;
  logic [NUM_SLV-1:0]             s_WVALID;
  logic [NUM_SLV-1:0]             s_WLAST;
  logic [NUM_SLV-1:0]             s_WREADY;

  modport master (
    output m0_WDATA, m0_WSTRB, m0_WVALID, m0_WLAST,
    input  m0_WREADY,
    output m1_WDATA, m1_WSTRB, m1_WVALID, m1_WLAST,
    input  m1_WREADY,
    input  s_WDATA, s_WSTRB, s_WVALID, s_WLAST,
    output s_WREADY
  );

  modport slave (
    input  m0_WDATA, m0_WSTRB, m0_WVALID, m0_WLAST,
    output m0_WREADY,
    input  m1_WDATA, m1_WSTRB, m1_WVALID, m1_WLAST,
    output m1_WREADY,
    output s_WDATA, s_WSTRB, s_WVALID, s_WLAST,
    input  s_WREADY
  );

endinterface

// File: rtl/axi_w_router_fifo.sv
// Write-order FIFO with occupancy count.
// Ports: clk_i/rst_i (async active-high), push_i/wdata_i write side,
// pop_i/rdata_c read side (rdata_c is the combinational head),
// full_o and count_o are registered.
// A push while full is honoured when a pop happens in the same cycle.
module axi_w_router_fifo #(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          rdata_c,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              push_en, pop_en;

  // Pointer/count update; pop frees the slot first so push-when-full works.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop_en   = pop_i && (count_q != '0);
    push_en  = push_i && (!full_q || pop_en);
    if (push_en) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  assign rdata_c = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign count_o = count_q;

endmodule

// File: rtl/axi_w_router.sv
// AXI write-data router for the 2-master / 4-slave interconnect.
// Records {slave, master} of each accepted AW in issue order and steers that
// master's W burst to that slave, one burst (through WLAST) at a time.
// Ports: clk_i/rst_i (async active-high); aw_push_i/aw_msel_i/aw_ssel_i order
// capture, aw_full_o back to the AW arbiter; w_if W bundle (combinational path
// master<->slave); busy_o, beat_cnt_o, ovf_o registered status.
module axi_w_router
  import axi_w_router_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_WIDTH,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned NUM_SLV = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       aw_push_i,
  input  logic [MSEL_W-1:0]          aw_msel_i,
  input  logic [$clog2(NUM_SLV)-1:0] aw_ssel_i,
  output logic                       aw_full_o,
  axi_w_router_if.slave              w_if,
  output logic                       busy_o,
  output logic [7:0]                 beat_cnt_o,
  output logic                       ovf_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic              ovf_q, ovf_d;

  w_order_t          push_entry;
  w_order_t          head_c;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              push_ok;

  logic              route_en;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;
  logic              sel_wvalid;
  logic              sel_wlast;
  logic              sel_wready;
  logic              beat_acc;
  logic              last_acc;

  assign push_entry.ssel = SSEL_W'(aw_ssel_i);
  assign push_entry.msel = aw_msel_i;

  axi_w_router_fifo #(
    .DATA_W (ORDER_W),
    .DEPTH  (DEPTH)
  ) u_order_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_ok),
    .wdata_i (push_entry),
    .pop_i   (last_acc),
    .rdata_c (head_c),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

  // Route mux: head entry connects one master to one slave, everything else held off.
  always_comb begin
    route_en      = (state_q == ST_ACTIVE);
    sel_wdata     = (head_c.msel == MSEL_DMAC) ? w_if.m1_WDATA  : w_if.m0_WDATA;
    sel_wstrb     = (head_c.msel == MSEL_DMAC) ? w_if.m1_WSTRB  : w_if.m0_WSTRB;
    sel_wvalid    = (head_c.msel == MSEL_DMAC) ? w_if.m1_WVALID : w_if.m0_WVALID;
    sel_wlast     = (head_c.msel == MSEL_DMAC) ? w_if.m1_WLAST  : w_if.m0_WLAST;
    sel_wready    = w_if.s_WREADY[head_c.ssel];
    w_if.s_WDATA  = '0;
    w_if.s_WSTRB  = '0;
    w_if.s_WVALID = '0;
    w_if.s_WLAST  = '0;
    w_if.m0_WREADY = 1'b0;
    w_if.m1_WREADY = 1'b0;
    if (route_en) begin
      w_if.s_WDATA[head_c.ssel]  = sel_wdata;
      w_if.s_WSTRB[head_c.ssel]  = sel_wstrb;
      w_if.s_WVALID[head_c.ssel] = sel_wvalid;
      w_if.s_WLAST[head_c.ssel]  = sel_wlast;
      if (head_c.msel == MSEL_DMAC) w_if.m1_WREADY = sel_wready;
      else                          w_if.m0_WREADY = sel_wready;
    end
    beat_acc = route_en && sel_wvalid && sel_wready;
    last_acc = beat_acc && sel_wlast;
  end

  // FSM and status next-state; route stays live while any entry remains after this edge.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    push_ok    = aw_push_i && (!fifo_full || last_acc);
    ovf_d      = ovf_q | (aw_push_i && !push_ok);
    cnt_nxt    = fifo_cnt + CNT_W'(push_ok) - CNT_W'(last_acc);
    case (state_q)
      ST_IDLE:   if (cnt_nxt != '0) state_d = ST_ACTIVE;
      ST_ACTIVE: if (last_acc && (cnt_nxt == '0)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (last_acc) begin
      beat_cnt_d = 8'd0;
    end else if (beat_acc && (beat_cnt_q != 8'hFF)) begin
      beat_cnt_d = beat_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= 8'd0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy_o     = (state_q == ST_ACTIVE);
  assign beat_cnt_o = beat_cnt_q;
  assign ovf_o      = ovf_q;
  assign aw_full_o  = fifo_full;

endmodule

// File: tb/tb_axi_w_router.sv
// Randomized bench for axi_w_router against a queue-based model of the
// write-order rules (outstanding AW entries, burst beat count, sticky overflow).
module tb_axi_w_router;
  import axi_w_router_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;

  typedef struct packed { logic [1:0] s; logic m; } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic       pmsel = 1'b0;
  logic [1:0] pssel = 2'd0;
  logic       aw_full_o, busy_o, ovf_o;
  logic [7:0] beat_cnt_o;

  logic [DW-1:0] wd [2];
  logic [3:0]    ws [2];
  logic          wv [2];
  logic          wl [2];
  logic [3:0]    srdy = 4'd0;

  ent_t q[$];
  int   m_beats = 0;
  bit   m_ovf = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  axi_w_router_if #(.DATA_W(DW), .NUM_SLV(4)) w_if ();

  assign w_if.m0_WDATA  = wd[0];
  assign w_if.m0_WSTRB  = ws[0];
  assign w_if.m0_WVALID = wv[0];
  assign w_if.m0_WLAST  = wl[0];
  assign w_if.m1_WDATA  = wd[1];
  assign w_if.m1_WSTRB  = ws[1];
  assign w_if.m1_WVALID = wv[1];
  assign w_if.m1_WLAST  = wl[1];
  assign w_if.s_WREADY  = srdy;

  axi_w_router #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_SLV(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .aw_push_i  (push),
    .aw_msel_i  (pmsel),
    .aw_ssel_i  (pssel),
    .aw_full_o  (aw_full_o),
    .w_if       (w_if),
    .busy_o     (busy_o),
    .beat_cnt_o (beat_cnt_o),
    .ovf_o      (ovf_o)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: compare all outputs with the model, then advance the model across the edge.
  task automatic cycle();
    ent_t h = '0;
    bit act, acc, pop, pacc;
    logic [3:0][DW-1:0] ed = '0;
    logic [3:0][3:0]    es = '0;
    logic [3:0]         ev = '0, el = '0;
    logic               er0 = 1'b0, er1 = 1'b0;
    #1;
    act = (q.size() != 0);
    if (act) begin
      h = q[0];
      ed[h.s] = wd[h.m];
      es[h.s] = ws[h.m];
      ev[h.s] = wv[h.m];
      el[h.s] = wl[h.m];
      if (h.m) er1 = srdy[h.s];
      else     er0 = srdy[h.s];
    end
    check("busy", busy_o, act);
    check("aw_full", aw_full_o, q.size() == DEPTH);
    check("beat_cnt", beat_cnt_o, m_beats);
    check("ovf", ovf_o, m_ovf);
    check("m0_wready", w_if.m0_WREADY, er0);
    check("m1_wready", w_if.m1_WREADY, er1);
    check("s_wvalid", w_if.s_WVALID, ev);
    check("s_wlast", w_if.s_WLAST, el);
    check("s_wdata", w_if.s_WDATA, ed);
    check("s_wstrb", w_if.s_WSTRB, es);
    acc  = act && wv[h.m] && srdy[h.s];
    pop  = acc && wl[h.m];
    pacc = push && ((q.size() < DEPTH) || pop);
    @(posedge clk);
    #1;
    if (push && !pacc) m_ovf = 1'b1;
    if (pop) m_beats = 0;
    else if (acc && m_beats < 255) m_beats++;
    if (pop) void'(q.pop_front());
    if (pacc) q.push_back('{s: pssel, m: pmsel});
  endtask

  task automatic rand_w(input int vpct, input int lpct);
    for (int i = 0; i < 2; i++) begin
      wd[i] = $urandom;
      ws[i] = 4'($urandom);
      wv[i] = ($urandom_range(0, 99) < vpct);
      wl[i] = ($urandom_range(0, 99) < lpct);
    end
  endtask

  task automatic rand_push(input int pct, input bit gate);
    push  = ($urandom_range(0, 99) < pct) && (!gate || q.size() < DEPTH);
    pmsel = 1'($urandom);
    pssel = 2'($urandom);
  endtask

  task automatic rand_phase(input int n, input int ppct, input bit gate);
    for (int c = 0; c < n; c++) begin
      rand_w(70, 25);
      srdy = 4'($urandom);
      rand_push(ppct, gate);
      cycle();
    end
  endtask

  task automatic drain();
    int budget = 4000;
    push = 1'b0;
    while (q.size() != 0 && budget > 0) begin
      rand_w(100, 50);
      srdy = 4'hF;
      cycle();
      budget--;
    end
    check("drain_left", q.size(), 0);
    check("drain_idle", busy_o, 1'b0);
  endtask

  initial begin
    ent_t h;
    for (int i = 0; i < 2; i++) begin
      wd[i] = '0; ws[i] = '0; wv[i] = 1'b0; wl[i] = 1'b0;
    end
    #1;
    check("rst_busy", busy_o, 1'b0);
    check("rst_full", aw_full_o, 1'b0);
    check("rst_beat", beat_cnt_o, 8'd0);
    check("rst_ovf", ovf_o, 1'b0);
    check("rst_svalid", w_if.s_WVALID, 4'd0);
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // Early W with nothing outstanding, then push {0,0} and watch the route appear.
    wv[0] = 1'b1; wd[0] = 32'hA0; ws[0] = 4'hF; wl[0] = 1'b0; srdy = 4'h1;
    cycle();
    push = 1'b1; pmsel = MSEL_CPU; pssel = SLV_0;
    cycle();
    push = 1'b0;
    cycle();
    drain();

    rand_phase(1500, 30, 1'b1);
    drain();

    // Beat counter saturation on a long m1 burst to s2.
    push = 1'b1; pmsel = MSEL_DMAC; pssel = SLV_2; wv[0] = 1'b0; wv[1] = 1'b0;
    cycle();
    push = 1'b0; wv[1] = 1'b1; wl[1] = 1'b0; srdy = 4'b0100;
    for (int i = 0; i < 260; i++) begin
      wd[1] = $urandom;
      cycle();
    end
    check("beat_sat", beat_cnt_o, 8'd255);
    wl[1] = 1'b1;
    cycle();
    wv[1] = 1'b0; wl[1] = 1'b0;
    cycle();
    check("beat_clr", beat_cnt_o, 8'd0);

    // Fill, overflow, then push together with a last beat while full.
    wv[0] = 1'b0; wv[1] = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      rand_push(100, 1'b0);
      cycle();
    end
    check("full_flag", aw_full_o, 1'b1);
    rand_push(100, 1'b0);
    cycle();
    check("ovf_set", ovf_o, 1'b1);
    h = q[0];
    wv[h.m] = 1'b1; wl[h.m] = 1'b1; wd[h.m] = $urandom; srdy = 4'h0;
    srdy[h.s] = 1'b1;
    rand_push(100, 1'b0);
    cycle();
    check("full_keep", aw_full_o, 1'b1);
    rand_phase(1000, 40, 1'b0);

    // Reset in the middle of a 4-beat burst.
    drain();
    push = 1'b1; pmsel = MSEL_CPU; pssel = SLV_3; wv[0] = 1'b0; wv[1] = 1'b0;
    cycle();
    push = 1'b1; pmsel = MSEL_DMAC; pssel = SLV_1;
    wv[0] = 1'b1; wl[0] = 1'b0; wd[0] = 32'hA0; srdy = 4'hF;
    cycle();
    push = 1'b0; wd[0] = 32'hA1;
    cycle();
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_beat", beat_cnt_o, 8'd0);
    check("mid_rst_m0rdy", w_if.m0_WREADY, 1'b0);
    check("mid_rst_svalid", w_if.s_WVALID, 4'd0);
    check("mid_rst_sdata", w_if.s_WDATA, 128'd0);
    check("mid_rst_ovf", ovf_o, 1'b0);
    q.delete();
    m_beats = 0;
    m_ovf = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    push = 1'b1; pmsel = MSEL_DMAC; pssel = SLV_1; wv[1] = 1'b1; wl[1] = 1'b1;
    cycle();
    push = 1'b0;
    cycle();
    rand_phase(500, 30, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
